// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes MULT/DIV results at issue
// and commits them after a fixed busy window so the stall controller can hold D.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          no_commit;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes; INT_MIN / -1 falls out as 0x80000000 rem 0.
  // A zero divisor is replaced by 1 only to keep the dividers defined; the
  // result is discarded through no_commit.
  assign a_mag    = a[31] ? (32'd0 - a) : a;
  assign b_mag    = b[31] ? (32'd0 - b) : b;
  assign b_safe_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe_u = (b == 32'd0) ? 32'd1 : b;
  assign q_mag    = a_mag / b_safe_s;
  assign r_mag    = a_mag % b_safe_s;
  assign q_s      = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s      = a[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u      = a / b_safe_u;
  assign r_u      = a % b_safe_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      no_commit <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      busy <= (cnt != CW'(1));
      if (cnt == CW'(1)) begin
        if (!no_commit) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
        no_commit <= 1'b0;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          {pend_hi, pend_lo} <= (md_op == OP_MULT) ? prod_s : prod_u;
          cnt  <= CW'(MULT_CYCLES);
          busy <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_lo   <= (md_op == OP_DIV) ? q_s : q_u;
          pend_hi   <= (md_op == OP_DIV) ? r_s : r_u;
          no_commit <= (b == 32'd0);
          cnt       <= CW'(DIV_CYCLES);
          busy      <= 1'b1;
        end
        OP_MTHI: hi_q <= a;
        OP_MTLO: lo_q <= a;
        default: ;
      endcase
    end
  end

  assign md_out = rd_sel ? hi_q : lo_q;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, alongside the ALU. It consumes the forwarded E-stage rs/rt operands and owns the HI/LO registers.
- Implements MULT, MULTU, DIV, DIVU, MTHI, MTLO as a multi-cycle unit. A busy indication drives the stall controller.
- Provides HI/LO readback for MFHI/MFLO, whose result is forwarded like an ALU result.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a MULT/MULTU issue (>=1)
- DIV_CYCLES, 10, cycles busy stays high after a DIV/DIVU issue (>=1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  an MDU instruction is in E this cycle (qualified; low during E bubble)
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- a  in  32  forwarded E rs value (dividend / multiplicand / MTHI-MTLO data)
- b  in  32  forwarded E rt value (divisor / multiplier)
- rd_sel  in  1  readback select: 0 = LO, 1 = HI
- busy  out  1  registered; high while a mult/div is in flight
- md_out  out  32  combinational; HI when rd_sel=1, else LO (committed values only)
- hi_q  out  32  committed HI (debug/trace)
- lo_q  out  32  committed LO (debug/trace)

Behaviour:
- Reset (synchronous, clk edge with reset=1): HI=0, LO=0, counter=0, busy=0, pending result discarded. Reset overrides all other inputs on that edge, including a mid-operation one.
- Issue is accepted on an edge where start=1, busy=0 and md_op in 1..6. Start while busy=1 is ignored entirely (no state change). The stall controller must make this unreachable; the bench checks it anyway.
- MULT/MULTU on issue:
  - Compute the 64-bit product: signed for MULT, unsigned for MULTU.
  - Latch it into the pending regs: pend_hi = product[63:32], pend_lo = product[31:0].
  - Load counter with MULT_CYCLES.
- DIV/DIVU on issue:
  - pend_lo = quotient, pend_hi = remainder.
  - DIV is signed, quotient truncated toward zero, remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU is unsigned.
  - Divisor 0: set a no-commit flag; HI/LO are not modified at completion. Busy timing is unchanged.
  - Load counter with DIV_CYCLES.
- Counter is unsigned, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - busy = (counter != 0), driven as a register.
  - Each edge with counter != 0 decrements it.
  - On the edge where counter goes 1 -> 0: HI<=pend_hi and LO<=pend_lo unless no-commit is set; no-commit is cleared.
  - Net effect: busy is high for exactly N cycles after the issue edge. New HI/LO are visible on md_out in the first cycle busy=0.
- MTHI/MTLO on issue (busy=0): HI<=a or LO<=a on that same edge. Busy is not asserted. Visible on md_out next cycle.
- md_out and hi_q/lo_q never show pending values.
- MFHI/MFLO needs no issue. md_out is combinational from the committed regs and rd_sel. The stall controller stalls D on any MDU-class instruction (including MFHI/MFLO) while (E start with md_op in 1..4) or busy.
- Completion edge coinciding with start: start is ignored because busy=1 that cycle. The next issue is accepted one cycle later.
- No combinational path from a/b to busy. The path to md_out exists only via rd_sel.
- The E-stage flush (E register reset on stall) deasserts start. The unit itself has no flush input, so an in-flight op always completes unless reset is asserted.

Test Plan:
1. Reset, then start MULT a=0xFFFFFFFD b=5 -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_out=LO with rd_sel=0 in the first busy=0 cycle.
2. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001. DIVU a=7 b=2 -> busy 10 cycles, then LO=3, HI=1.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI a=0x12345678, then DIV a=9 b=0 -> busy 10 cycles, HI stays 0x12345678, LO stays 0.
5. Issue MULT, then assert start with MTLO a=0xDEAD while busy -> ignored; LO equals the product low word after completion, never 0xDEAD.
6. Issue DIVU a=100 b=3, assert reset at busy cycle 4 -> next cycle busy=0, HI=LO=0, and no later commit occurs.
